cpu_control: RTL

Multicycle control FSM for the 16-bit CR16-subset processor. It reads the instruction register and processor status register held by the processor-register block and drives that block's `pc_en`, `instr_en` and flag enables. It also drives the register-file, memory and datapath mux selects. It is the consumer and sequencer on the other side of the PSR/PC/INSTR register interface.

---
 rtl/cpu_control.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cpu_control.sv
// Multicycle control FSM for the CR16-subset core: sequences FETCH/LATCH/EXEC(/LOADWB) and decodes instr in EXEC.
// Outputs are combinational from state and instr; reset forces every enable and select to 0 in the same cycle.
module cpu_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic [15:0] psr,
    output logic        pc_en,
    output logic        instr_en,
    output logic        cmp_f_en,
    output logic        of_f_en,
    output logic        z_f_en,
    output logic        rf_wr_en,
    output logic        mem_wr_en,
    output logic        addr_sel,
    output logic        alu_b_imm,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        LATCH  = 2'd1,
        EXEC   = 2'd2,
        LOADWB = 2'd3
    } state_t;

    state_t cur;
    state_t nxt;

    logic [3:0] op;
    logic [3:0] ext;
    logic [3:0] cond;
    logic [3:0] alu_code;
    logic       is_load;
    logic       taken;
    logic       flag_c, flag_l, flag_f, flag_z, flag_n;
    logic       unused_bits;

    assign op     = instr[15:12];
    assign ext    = instr[7:4];
    assign cond   = instr[11:8];
    assign flag_c = psr[0];
    assign flag_l = psr[2];
    assign flag_f = psr[5];
    assign flag_z = psr[6];
    assign flag_n = psr[7];

    // Register operand fields and the non-flag PSR bits belong to the datapath, not this block.
    assign unused_bits = ^{psr[15:8], psr[4:3], psr[1], instr[3:0]};

    assign is_load = (op == 4'b0100) && (ext == 4'b0000);
    assign state   = cur;

    function automatic logic is_alu(input logic [3:0] c);
        return c inside {4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101};
    endfunction

    always_comb begin
        taken = 1'b0;
        case (cond)
            4'b0000: taken = flag_z;
            4'b0001: taken = !flag_z;
            4'b0010: taken = flag_c;
            4'b0011: taken = !flag_c;
            4'b0100: taken = flag_l;
            4'b0101: taken = !flag_l;
            4'b0110: taken = flag_n;
            4'b0111: taken = !flag_n;
            4'b1000: taken = flag_f;
            4'b1001: taken = !flag_f;
            4'b1010: taken = !flag_l && !flag_z;
            4'b1011: taken = flag_l || flag_z;
            4'b1100: taken = !flag_n && !flag_z;
            4'b1101: taken = flag_n || flag_z;
            4'b1110: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = LATCH;
            LATCH:   nxt = EXEC;
            EXEC:    nxt = is_load ? LOADWB : FETCH;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            cur <= FETCH;
        else
            cur <= nxt;
    end

    always_comb begin
        pc_en     = 1'b0;
        instr_en  = 1'b0;
        cmp_f_en  = 1'b0;
        of_f_en   = 1'b0;
        z_f_en    = 1'b0;
        rf_wr_en  = 1'b0;
        mem_wr_en = 1'b0;
        addr_sel  = 1'b0;
        alu_b_imm = 1'b0;
        pc_sel    = 2'd0;
        wb_sel    = 2'd0;
        alu_code  = (op == 4'b0000) ? ext : op;
        if (!reset) begin
            case (cur)
                LATCH: instr_en = 1'b1;
                EXEC: begin
                    pc_en = 1'b1;
                    if (op == 4'b0000 || is_alu(op)) begin
                        // R-type uses ext as the ALU code; immediate forms reuse the same nibble as op.
                        alu_b_imm = (op != 4'b0000);
                        case (alu_code)
                            4'b0101, 4'b1001: begin
                                rf_wr_en = 1'b1;
                                of_f_en  = 1'b1;
                            end
                            4'b1011: begin
                                cmp_f_en = 1'b1;
                                z_f_en   = 1'b1;
                            end
                            4'b0001, 4'b0010, 4'b0011, 4'b1101: rf_wr_en = 1'b1;
                            default: alu_b_imm = 1'b0;
                        endcase
                    end else if (op == 4'b0100) begin
                        case (ext)
                            4'b0000: begin
                                addr_sel = 1'b1;
                                pc_en    = 1'b0;
                            end
                            4'b0100: begin
                                addr_sel  = 1'b1;
                                mem_wr_en = 1'b1;
                            end
                            4'b1100: pc_sel = taken ? 2'd2 : 2'd0;
                            4'b1000: begin
                                pc_sel   = 2'd2;
                                wb_sel   = 2'd2;
                                rf_wr_en = 1'b1;
                            end
                            default: ;
                        endcase
                    end else if (op == 4'b1100) begin
                        pc_sel = taken ? 2'd1 : 2'd0;
                    end
                end
                LOADWB: begin
                    addr_sel = 1'b1;
                    wb_sel   = 2'd1;
                    rf_wr_en = 1'b1;
                    pc_en    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
